// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the dm_arbiter data-memory access controller.
// Optional feature macro used by this slice: DM_ARBITER_RR_EN (round-robin selection).
package dm_arbiter_pkg;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 32;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

endpackage

// File: rtl/dm_arbiter_pick.sv
// Combinational winner selection between the two requesters.
// DM_ARBITER_RR_EN defined: ptr names the preferred port on a tie; undefined: port 0 wins ties.
module dm_arbiter_pick
   import dm_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic win,
   output logic vld
);

   assign vld = req0 | req1;

`ifdef DM_ARBITER_RR_EN
   // A lone requester wins regardless of ptr; ptr only breaks ties.
   assign win = req1 & (~req0 | (ptr == OWN_DBG));
`else
   logic unused_ptr;
   assign unused_ptr = ptr;
   assign win = req1 & ~req0;
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Two-port access controller sharing the single-port data memory between CPU (port 0)
// and debug/DMA (port 1). Define DM_ARBITER_RR_EN for round-robin tie-breaking.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | sample requests, register the winner on the way to ACC
//   ACC     | gnt pulse, memory lines driven from the registered request
//   RSP     | done pulse to the owner, rdata valid for a read
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          done0,
   output logic          done1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_din,
   output logic          dm_wr,
   output logic          dm_rd,
   input  logic [DW-1:0] dm_dout
);

   state_t        state;
   logic          we_q;
   logic          owner;
   logic          ptr;
   logic          win;
   logic          vld;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   dm_arbiter_pick u_pick (
      .req0 (req0),
      .req1 (req1),
      .ptr  (ptr),
      .win  (win),
      .vld  (vld)
   );

   assign sel_we    = (win == OWN_DBG) ? we1    : we0;
   assign sel_addr  = (win == OWN_DBG) ? addr1  : addr0;
   assign sel_wdata = (win == OWN_DBG) ? wdata1 : wdata0;

`ifdef DM_ARBITER_RR_EN
   // After each grant the preference moves to the port that was not served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= OWN_CPU;
      end else if (state == ST_IDLE && vld) begin
         ptr <= ~win;
      end
   end
`else
   assign ptr = OWN_CPU;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         we_q    <= 1'b0;
         owner   <= OWN_CPU;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         rdata   <= '0;
         dm_addr <= '0;
         dm_din  <= '0;
         dm_wr   <= 1'b0;
         dm_rd   <= 1'b0;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         dm_wr <= 1'b0;
         dm_rd <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (vld) begin
                  state   <= ST_ACC;
                  we_q    <= sel_we;
                  owner   <= win;
                  gnt0    <= (win == OWN_CPU);
                  gnt1    <= (win == OWN_DBG);
                  dm_addr <= sel_addr;
                  dm_din  <= sel_wdata;
                  dm_wr   <= sel_we;
                  dm_rd   <= ~sel_we;
               end
            end
            ST_ACC: begin
               state <= ST_RSP;
               // A write leaves the last read result in place.
               if (!we_q) begin
                  rdata <= dm_dout;
               end
               done0 <= (owner == OWN_CPU);
               done1 <= (owner == OWN_DBG);
            end
            ST_RSP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural dm_4k model.
module tb_dm_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, done0, done1, busy, dm_wr, dm_rd;
   logic [DW-1:0] rdata, dm_din, dm_dout;
   logic [AW-1:0] dm_addr;

   logic [DW-1:0] mem [1024];

   int pass_cnt = 0;
   int total_cnt = 0;

   dm_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0),
      .req1    (req1),
      .we0     (we0),
      .we1     (we1),
      .addr0   (addr0),
      .addr1   (addr1),
      .wdata0  (wdata0),
      .wdata1  (wdata1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .done0   (done0),
      .done1   (done1),
      .rdata   (rdata),
      .busy    (busy),
      .dm_addr (dm_addr),
      .dm_din  (dm_din),
      .dm_wr   (dm_wr),
      .dm_rd   (dm_rd),
      .dm_dout (dm_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_dout = mem[dm_addr];
   always @(posedge clk) begin
      if (dm_wr) mem[dm_addr] <= dm_din;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      tick; tick;
      total_cnt++;
      if ({gnt0, gnt1, done0, done1, busy, dm_wr, dm_rd} !== 7'b0)
         $display("FAIL reset_ctl: got %b want 0000000", {gnt0, gnt1, done0, done1, busy, dm_wr, dm_rd});
      else pass_cnt++;
      total_cnt++;
      if ({rdata, dm_din} !== 64'h0) $display("FAIL reset_data: rdata %h dm_din %h want 0", rdata, dm_din);
      else pass_cnt++;
      total_cnt++;
      if (dm_addr !== 10'h0) $display("FAIL reset_addr: got %h want 000", dm_addr);
      else pass_cnt++;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         total_cnt++;
         if ({busy, dm_wr, dm_rd} !== 3'b000) $display("FAIL idle_quiet[%0d]: got %b want 000", i, {busy, dm_wr, dm_rd});
         else pass_cnt++;
      end
   endtask

   task automatic test_write_read;
      issue(1'b0, 1'b1, 10'h004, 32'hDEADBEEF);
      tick;
      total_cnt++;
      if ({gnt0, gnt1, dm_wr, dm_rd, busy} !== 5'b10101) $display("FAIL wr_acc_ctl: got %b want 10101", {gnt0, gnt1, dm_wr, dm_rd, busy});
      else pass_cnt++;
      total_cnt++;
      if (dm_addr !== 10'h004 || dm_din !== 32'hDEADBEEF) $display("FAIL wr_acc_bus: addr %h din %h want 004 deadbeef", dm_addr, dm_din);
      else pass_cnt++;
      req0 = 1'b0;
      tick;
      total_cnt++;
      if ({gnt0, done0, done1, dm_wr, busy} !== 5'b01001) $display("FAIL wr_rsp: got %b want 01001", {gnt0, done0, done1, dm_wr, busy});
      else pass_cnt++;
      tick;
      total_cnt++;
      if ({busy, done0} !== 2'b00) $display("FAIL wr_idle: got %b want 00", {busy, done0});
      else pass_cnt++;
      issue(1'b0, 1'b0, 10'h004, 32'h0);
      tick;
      total_cnt++;
      if ({gnt0, dm_wr, dm_rd} !== 3'b101) $display("FAIL rd_acc: got %b want 101", {gnt0, dm_wr, dm_rd});
      else pass_cnt++;
      req0 = 1'b0;
      tick;
      total_cnt++;
      if (done0 !== 1'b1 || rdata !== 32'hDEADBEEF) $display("FAIL rd_rsp: done0 %b rdata %h want 1 deadbeef", done0, rdata);
      else pass_cnt++;
      tick;
   endtask

   task automatic test_simultaneous;
      issue(1'b1, 1'b1, 10'h020, 32'hCAFEF00D);
      tick; req1 = 1'b0; tick; tick;
      issue(1'b0, 1'b0, 10'h004, 32'h0);
      issue(1'b1, 1'b0, 10'h020, 32'h0);
      tick;
      total_cnt++;
      if ({gnt0, gnt1} !== 2'b10) $display("FAIL tie_first: got %b want 10", {gnt0, gnt1});
      else pass_cnt++;
      req0 = 1'b0;
      tick;
      total_cnt++;
      if ({done0, done1} !== 2'b10 || rdata !== 32'hDEADBEEF) $display("FAIL tie_done0: done %b rdata %h want 10 deadbeef", {done0, done1}, rdata);
      else pass_cnt++;
      tick;
      total_cnt++;
      if ({busy, gnt1} !== 2'b00) $display("FAIL tie_wait: got %b want 00", {busy, gnt1});
      else pass_cnt++;
      tick;
      total_cnt++;
      if ({gnt0, gnt1} !== 2'b01 || dm_addr !== 10'h020) $display("FAIL tie_second: gnt %b addr %h want 01 020", {gnt0, gnt1}, dm_addr);
      else pass_cnt++;
      req1 = 1'b0;
      tick;
      total_cnt++;
      if ({done0, done1} !== 2'b01 || rdata !== 32'hCAFEF00D) $display("FAIL tie_done1: done %b rdata %h want 01 cafef00d", {done0, done1}, rdata);
      else pass_cnt++;
      tick;
   endtask

   task automatic test_rdata_hold;
      issue(1'b0, 1'b1, 10'h010, 32'h12345678);
      tick; req0 = 1'b0; tick; tick;
      issue(1'b0, 1'b0, 10'h010, 32'h0);
      tick; req0 = 1'b0; tick;
      total_cnt++;
      if (done0 !== 1'b1 || rdata !== 32'h12345678) $display("FAIL hold_read: done0 %b rdata %h want 1 12345678", done0, rdata);
      else pass_cnt++;
      tick;
      issue(1'b0, 1'b1, 10'h011, 32'h0);
      tick; req0 = 1'b0; tick;
      total_cnt++;
      if (done0 !== 1'b1 || rdata !== 32'h12345678) $display("FAIL hold_write: done0 %b rdata %h want 1 12345678", done0, rdata);
      else pass_cnt++;
      tick;
      total_cnt++;
      if (mem[10'h011] !== 32'h0) $display("FAIL hold_mem: got %h want 00000000", mem[10'h011]);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_gnt [4];
`ifdef DM_ARBITER_RR_EN
      exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
      // Serve port 1 once so the preference points at port 0.
      issue(1'b1, 1'b1, 10'h030, 32'h0000_0030);
      tick; req1 = 1'b0; tick; tick;
`else
      exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b10;
`endif
      issue(1'b0, 1'b0, 10'h004, 32'h0);
      issue(1'b1, 1'b0, 10'h020, 32'h0);
      for (int k = 0; k < 4; k++) begin
         tick;
         total_cnt++;
         if ({gnt0, gnt1} !== exp_gnt[k]) $display("FAIL b2b_gnt[%0d]: got %b want %b", k, {gnt0, gnt1}, exp_gnt[k]);
         else pass_cnt++;
         tick;
         total_cnt++;
         if ({done0, done1} !== exp_gnt[k]) $display("FAIL b2b_done[%0d]: got %b want %b", k, {done0, done1}, exp_gnt[k]);
         else pass_cnt++;
         tick;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      tick; tick; tick;
   endtask

   task automatic test_reset_mid;
      issue(1'b1, 1'b0, 10'h020, 32'h0);
      tick;
      total_cnt++;
      if ({gnt1, dm_rd} !== 2'b11) $display("FAIL mid_acc: got %b want 11", {gnt1, dm_rd});
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({dm_rd, gnt1, busy} !== 3'b000) $display("FAIL mid_drop: got %b want 000", {dm_rd, gnt1, busy});
      else pass_cnt++;
      req1 = 1'b0;
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         total_cnt++;
         if ({done1, busy} !== 2'b00) $display("FAIL mid_after[%0d]: got %b want 00", i, {done1, busy});
         else pass_cnt++;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      test_reset;
      test_write_read;
      test_simultaneous;
      test_rdata_hold;
      test_back_to_back;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
